// File: rtl/key_led_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : key_led_ctrl                                                      |
// | Brief   : Multi-channel key debouncer with direct/toggle/blink LED drive.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_led_ctrl #(
  parameter int CH_NUM         = 4,
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int BLINK_HALF_CYC = 25_000_000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CH_NUM-1:0] key,
  input  logic [1:0]        mode,
  output logic [CH_NUM-1:0] key_press,
  output logic [CH_NUM-1:0] led
);

  localparam int              c_cnt_w = $clog2(DEBOUNCE_CYC);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYC - 1);
  localparam int              c_pre_w = $clog2(BLINK_HALF_CYC);
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(BLINK_HALF_CYC - 1);
  // Pin level seen while the key is released.
  localparam logic            c_rel = (KEY_ACTIVE_LOW != 0);

  localparam logic [1:0] c_mode_direct = 2'b00;
  localparam logic [1:0] c_mode_toggle = 2'b01;
  localparam logic [1:0] c_mode_blink  = 2'b10;

  logic [c_pre_w-1:0] r_pre;
  logic               r_phase;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pre   <= '0;
      r_phase <= 1'b0;
    end else if (r_pre == c_pre_max) begin
      r_pre   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic               r_tog;
    logic               r_ben;
    logic               r_press;
    logic               r_led;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;
    logic               w_press;
    logic               w_pressed;

    assign w_accept  = (r_s2 != r_stable) && (r_cnt == c_cnt_max);
    assign w_press   = w_accept && (r_s2 != c_rel);
    assign w_pressed = (r_stable != c_rel);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        r_s1     <= c_rel;
        r_s2     <= c_rel;
        r_stable <= c_rel;
        r_cnt    <= '0;
        r_tog    <= 1'b0;
        r_ben    <= 1'b0;
        r_press  <= 1'b0;
        r_led    <= 1'b0;
      end else begin
        r_s1 <= key[i];
        r_s2 <= r_s1;
        if (r_s2 == r_stable) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_stable <= r_s2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        // Toggle state flips on the accept edge so toggle mode has direct-mode latency.
        r_press <= w_press;
        if (w_press) begin
          r_tog <= ~r_tog;
          r_ben <= ~r_ben;
        end
        case (mode)
          c_mode_direct: r_led <= w_pressed;
          c_mode_toggle: r_led <= r_tog;
          c_mode_blink:  r_led <= r_ben & r_phase;
          default:       r_led <= 1'b0;
        endcase
      end
    end

    assign key_press[i] = r_press;
    assign led[i]       = r_led;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_led_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_key_led_ctrl                                                   |
// | Brief   : Scoreboard bench for key_led_ctrl against a behavioural model.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_key_led_ctrl;

  localparam int CH  = 4;
  localparam int DEB = 4;
  localparam int BHC = 8;
  localparam int KAL = 1;

  logic          clk;
  logic          rst;
  logic [CH-1:0] key;
  logic [1:0]    mode;
  logic [CH-1:0] key_press;
  logic [CH-1:0] led;

  key_led_ctrl #(
    .CH_NUM         (CH),
    .DEBOUNCE_CYC   (DEB),
    .BLINK_HALF_CYC (BHC),
    .KEY_ACTIVE_LOW (KAL)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .key       (key),
    .mode      (mode),
    .key_press (key_press),
    .led       (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [CH-1:0] led;
    logic [CH-1:0] kp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: raw pin history, consecutive-disagreement run lengths,
  // press counts (parity gives toggle/blink enable) and elapsed cycles for phase.
  logic [CH-1:0] m_s1;
  logic [CH-1:0] m_s2;
  bit   [CH-1:0] m_down;
  int            m_run[CH];
  int            m_presses[CH];
  int            m_n;

  always @(posedge clk) begin
    exp_t          e;
    logic [CH-1:0] d;
    bit            lvl;
    int            ph;
    e.led = '0;
    e.kp  = '0;
    if (rst) begin
      m_s1   = {CH{1'b1}};
      m_s2   = {CH{1'b1}};
      m_down = '0;
      m_n    = 0;
      for (int i = 0; i < CH; i++) begin
        m_run[i]     = 0;
        m_presses[i] = 0;
      end
    end else begin
      d    = m_s2;
      m_s2 = m_s1;
      m_s1 = key;
      ph   = (m_n / BHC) % 2;
      m_n  = m_n + 1;
      for (int i = 0; i < CH; i++) begin
        case (mode)
          2'd0: e.led[i] = m_down[i];
          2'd1: e.led[i] = (m_presses[i] % 2) == 1;
          2'd2: e.led[i] = ((m_presses[i] % 2) == 1) && (ph == 1);
          default: e.led[i] = 1'b0;
        endcase
        lvl = (d[i] != 1'(KAL));
        if (lvl == m_down[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_down[i] = lvl;
            m_run[i]  = 0;
            if (lvl) begin
              e.kp[i]      = 1'b1;
              m_presses[i] = m_presses[i] + 1;
            end
          end
        end
      end
    end
    q.push_back(e);
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_empty @%0t: got no expected entry, required one", $time);
      end else begin
        e = q.pop_front();
        checks++;
        if (led !== e.led) begin
          errors++;
          $display("FAIL led @%0t: got %h required %h", $time, led, e.led);
        end
        checks++;
        if (key_press !== e.kp) begin
          errors++;
          $display("FAIL key_press @%0t: got %h required %h", $time, key_press, e.kp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int ch, input int low, input int high);
    key[ch] = 1'b0;
    step(low);
    key[ch] = 1'b1;
    step(high);
  endtask

  initial begin
    rst  = 1'b1;
    key  = 4'hF;
    mode = 2'b00;
    step(3);
    rst = 1'b0;
    step(10);

    // Reset asserted mid-debounce must discard the pending press.
    key[0] = 1'b0;
    step(4);
    rst = 1'b1;
    step(2);
    key = 4'hF;
    rst = 1'b0;
    step(8);

    // Direct mode press and release.
    press(0, 12, 12);

    // Glitch rejection then a just-long-enough press.
    press(1, 3, 8);
    press(1, 4, 10);

    // Toggle mode with a detour through direct mode.
    mode = 2'b01;
    press(2, 8, 8);
    press(2, 8, 8);
    mode = 2'b00;
    step(5);
    mode = 2'b01;
    step(3);
    press(2, 8, 8);

    // Blink mode.
    mode = 2'b10;
    press(3, 8, 8);
    step(40);
    press(3, 8, 8);
    step(20);
    press(3, 8, 8);
    mode = 2'b11;
    step(20);

    // Simultaneous presses in every mode.
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      key  = 4'h0;
      step(8);
      key  = 4'hF;
      step(8);
    end

    // Randomized key activity and mode changes.
    for (int it = 0; it < 400; it++) begin
      key = 4'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step($urandom_range(1, 8));
    end

    key = 4'hF;
    step(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
